// File: rtl/sample_extend_arbiter.sv
// sample_extend_arbiter
// Two requesters share one sign-extension stage. A round-robin arbiter picks
// one sample per cycle, widens it from WIDTH to WIDTH+EXT bits by MSB
// replication, and queues it with its channel tag in a small FIFO that a
// valid/ready consumer drains. Back-pressure stall cycles are counted for debug.
module sample_extend_arbiter #(
   parameter int WIDTH = 16,
   parameter int EXT   = 8,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in0_valid,
   input  logic [WIDTH-1:0]       in0_data,
   output logic                   in0_ready,
   input  logic                   in1_valid,
   input  logic [WIDTH-1:0]       in1_data,
   output logic                   in1_ready,
   output logic                   out_valid,
   output logic [WIDTH+EXT-1:0]   out_data,
   output logic                   out_chan,
   input  logic                   out_ready,
   input  logic                   stall_clr,
   output logic [CNT_W-1:0]       stall_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int OW = WIDTH + EXT;

   // FIFO storage: widened sample plus channel tag per entry
   logic [OW-1:0]    mem_data [DEPTH];
   logic [DEPTH-1:0] mem_chan;

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          last_grant;

   logic          space;
   logic          grant_valid;
   logic          grant_idx;
   logic [WIDTH-1:0] sel_data;
   logic [OW-1:0]    ext_data;
   logic          push;
   logic          pop;
   logic          stall;

   // A pop in the same cycle does not free a slot: no pass-through when full.
   assign space = (count < CW'(DEPTH));

   // Round-robin grant: on contention, favour the requester that did not win last
   always_comb begin
      // NOTE: every always_comb output gets a default first so that no path
      // leaves it unassigned, which would infer a latch.
      grant_valid = 1'b0;
      grant_idx   = 1'b0;
      if (space) begin
         if (in0_valid && in1_valid) begin
            grant_valid = 1'b1;
            grant_idx   = ~last_grant;
         end else if (in0_valid) begin
            grant_valid = 1'b1;
            grant_idx   = 1'b0;
         end else if (in1_valid) begin
            grant_valid = 1'b1;
            grant_idx   = 1'b1;
         end
      end
   end

   assign in0_ready = grant_valid && (grant_idx == 1'b0);
   assign in1_ready = grant_valid && (grant_idx == 1'b1);

   assign sel_data  = grant_idx ? in1_data : in0_data;
   assign ext_data  = {{EXT{sel_data[WIDTH-1]}}, sel_data};

   // A grant is only issued to a valid requester, so every grant is a transfer
   assign push      = grant_valid;
   assign out_valid = (count != '0);
   assign pop       = out_valid && out_ready;
   assign stall     = (in0_valid || in1_valid) && !space;

   // Head entry comes straight from the storage flops, never from the inputs
   assign out_data  = mem_data[rd_ptr];
   assign out_chan  = mem_chan[rd_ptr];

   // Storage write: the granted, widened sample lands at the write pointer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: the storage is reset because the head entry drives out_data
         // directly and must read as zero after reset; at this depth the
         // entries are ordinary flops, so the reset costs nothing notable.
         for (int i = 0; i < DEPTH; i++) begin
            mem_data[i] <= '0;
         end
         mem_chan <= '0;
      end else if (push) begin
         // NOTE: sequential state always uses non-blocking assignments so all
         // flops update together from pre-edge values.
         mem_data[wr_ptr] <= ext_data;
         mem_chan[wr_ptr] <= grant_idx;
      end
   end

   // Pointers, occupancy and arbitration history
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         last_grant <= 1'b1;
      end else begin
         if (push) begin
            wr_ptr     <= wr_ptr + PW'(1);
            last_grant <= grant_idx;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Saturating stall counter; a clear wins over a same-cycle increment
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_count <= '0;
      end else if (stall_clr) begin
         stall_count <= '0;
      end else if (stall && (stall_count != '1)) begin
         stall_count <= stall_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_sample_extend_arbiter.sv
// tb_sample_extend_arbiter
// Directed, table-driven bench for sample_extend_arbiter. Inputs are driven
// just after the rising edge, outputs are compared on the falling edge.
// The stall counter is built 4 bits wide so saturation is reachable quickly.
module tb_sample_extend_arbiter;

   localparam int WIDTH = 16;
   localparam int EXT   = 8;
   localparam int DEPTH = 4;
   localparam int CNT_W = 4;

   logic                 clk;
   logic                 reset;
   logic                 in0_valid;
   logic [WIDTH-1:0]     in0_data;
   logic                 in0_ready;
   logic                 in1_valid;
   logic [WIDTH-1:0]     in1_data;
   logic                 in1_ready;
   logic                 out_valid;
   logic [WIDTH+EXT-1:0] out_data;
   logic                 out_chan;
   logic                 out_ready;
   logic                 stall_clr;
   logic [CNT_W-1:0]     stall_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        v0;
      logic [15:0] d0;
      logic        v1;
      logic [15:0] d1;
      logic        ordy;
      logic        clr;
      logic        r0;
      logic        r1;
      logic        ov;
      logic [23:0] od;
      logic        oc;
      logic [3:0]  sc;
   } vec_t;

   vec_t vecs[$];

   sample_extend_arbiter #(
      .WIDTH(WIDTH), .EXT(EXT), .DEPTH(DEPTH), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset),
      .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
      .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
      .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan),
      .out_ready(out_ready), .stall_clr(stall_clr), .stall_count(stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input int v0, input int d0, input int v1, input int d1,
                               input int ordy, input int clr, input int r0, input int r1,
                               input int ov, input int od, input int oc, input int sc);
      vec_t r;
      r.v0 = v0[0];  r.d0 = d0[15:0]; r.v1 = v1[0]; r.d1 = d1[15:0];
      r.ordy = ordy[0]; r.clr = clr[0];
      r.r0 = r0[0];  r.r1 = r1[0];    r.ov = ov[0];  r.od = od[23:0];
      r.oc = oc[0];  r.sc = sc[3:0];
      return r;
   endfunction

   task automatic drive(input logic v0, input logic [15:0] d0, input logic v1,
                        input logic [15:0] d1, input logic ordy, input logic clr);
      in0_valid = v0; in0_data = d0;
      in1_valid = v1; in1_data = d1;
      out_ready = ordy; stall_clr = clr;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] gd [10];
      logic [23:0] gh [12];
      int j;
      int exp_od;

      gd = '{16'h7FFF, 16'h0000, 16'h1234, 16'h8765, 16'hABCD,
             16'h0001, 16'hFFFE, 16'h4000, 16'hC000, 16'h5555};
      gh = '{24'hFFFFFF, 24'hFF8000, 24'h007FFF, 24'h000000, 24'h001234, 24'hFF8765,
             24'hFFABCD, 24'h000001, 24'hFFFFFE, 24'h004000, 24'hFFC000, 24'h005555};

      // Reset and first contention: requester 0 wins
      vecs.push_back(mk(1,'h8001,1,'h0002,1,0, 1,0,0,0,0,0));
      vecs.push_back(mk(1,'h8001,1,'h0002,1,0, 0,1,1,'hFF8001,0,0));
      vecs.push_back(mk(0,0,0,0,1,0, 0,0,1,'h000002,1,0));
      vecs.push_back(mk(0,0,0,0,1,0, 0,0,0,0,0,0));

      // Round-robin: both valid for 8 cycles, grants alternate from 0
      for (int k = 0; k < 8; k++) begin
         j = k - 1;
         exp_od = (j % 2 == 0) ? ('h001000 + j) : ('h002000 + j);
         vecs.push_back(mk(1,'h1000 + k,1,'h2000 + k,1,0,
                           (k % 2 == 0) ? 1 : 0, k % 2, (k > 0) ? 1 : 0,
                           exp_od, (j % 2 == 0) ? 0 : 1, 0));
      end
      vecs.push_back(mk(0,0,0,0,1,0, 0,0,1,'h002007,1,0));

      // Fill with back-pressure, then stall cycles
      for (int k = 1; k <= 4; k++)
         vecs.push_back(mk(1,k,0,0,0,0, 1,0,(k > 1) ? 1 : 0,'h000001,0,0));
      vecs.push_back(mk(1,5,0,0,0,0, 0,0,1,'h000001,0,0));
      vecs.push_back(mk(1,5,0,0,0,0, 0,0,1,'h000001,0,1));
      vecs.push_back(mk(1,5,0,0,0,0, 0,0,1,'h000001,0,2));

      // Full with a single-cycle pop: no accept that cycle, accept the next
      vecs.push_back(mk(1,5,0,0,1,0, 0,0,1,'h000001,0,3));
      vecs.push_back(mk(1,5,0,0,0,0, 1,0,1,'h000002,0,4));
      vecs.push_back(mk(1,5,0,0,0,0, 0,0,1,'h000002,0,4));

      // Drain in acceptance order
      vecs.push_back(mk(0,0,0,0,1,0, 0,0,1,'h000002,0,5));
      vecs.push_back(mk(0,0,0,0,1,0, 0,0,1,'h000003,0,5));
      vecs.push_back(mk(0,0,0,0,1,0, 0,0,1,'h000004,0,5));
      vecs.push_back(mk(0,0,0,0,1,0, 0,0,1,'h000005,0,5));
      vecs.push_back(mk(0,0,0,0,1,0, 0,0,0,0,0,5));

      // Build count=2 on channel 1, then simultaneous push/pop across the wrap
      vecs.push_back(mk(0,0,1,'hFFFF,0,0, 0,1,0,0,0,5));
      vecs.push_back(mk(0,0,1,'h8000,0,0, 0,1,1,gh[0],1,5));
      for (int k = 0; k < 10; k++)
         vecs.push_back(mk(0,0,1,gd[k],1,0, 0,1,1,gh[k],1,5));
      vecs.push_back(mk(0,0,0,0,1,0, 0,0,1,gh[10],1,5));
      vecs.push_back(mk(0,0,0,0,1,0, 0,0,1,gh[11],1,5));
      vecs.push_back(mk(0,0,0,0,1,0, 0,0,0,0,0,5));

      // Reset state
      reset = 1'b1;
      drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
      #12;
      check("reset out_valid", 32'(out_valid), 32'h0);
      check("reset out_data", 32'(out_data), 32'h0);
      check("reset out_chan", 32'(out_chan), 32'h0);
      check("reset stall_count", 32'(stall_count), 32'h0);
      check("reset in0_ready idle", 32'(in0_ready), 32'h0);
      next_cycle();
      reset = 1'b0;

      // Table-driven vectors
      foreach (vecs[i]) begin
         drive(vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1, vecs[i].ordy, vecs[i].clr);
         @(negedge clk);
         check($sformatf("row%0d in0_ready", i), 32'(in0_ready), 32'(vecs[i].r0));
         check($sformatf("row%0d in1_ready", i), 32'(in1_ready), 32'(vecs[i].r1));
         check($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
         check($sformatf("row%0d stall_count", i), 32'(stall_count), 32'(vecs[i].sc));
         if (vecs[i].ov) begin
            check($sformatf("row%0d out_data", i), 32'(out_data), 32'(vecs[i].od));
            check($sformatf("row%0d out_chan", i), 32'(out_chan), 32'(vecs[i].oc));
         end
         next_cycle();
      end

      // Clear the counter from its value of 5
      drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
      next_cycle();
      drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
      @(negedge clk);
      check("clear idle stall_count", 32'(stall_count), 32'h0);
      next_cycle();

      // Fill four entries, then 20 stall cycles: counter saturates at 4'hF
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 16'(k), 1'b0, '0, 1'b0, 1'b0);
         next_cycle();
      end
      for (int k = 0; k < 20; k++) next_cycle();
      @(negedge clk);
      check("saturate stall_count", 32'(stall_count), 32'hF);
      check("saturate in0_ready", 32'(in0_ready), 32'h0);
      check("saturate out_valid", 32'(out_valid), 32'h1);
      next_cycle();

      // Clear together with a stall cycle: clear wins
      drive(1'b1, '0, 1'b0, '0, 1'b0, 1'b1);
      next_cycle();
      drive(1'b1, '0, 1'b0, '0, 1'b0, 1'b0);
      @(negedge clk);
      check("clear over stall stall_count", 32'(stall_count), 32'h0);
      next_cycle();
      @(negedge clk);
      check("count after clear stall_count", 32'(stall_count), 32'h1);
      check("pre-reset out_valid", 32'(out_valid), 32'h1);

      // Asynchronous reset mid-burst empties the queue immediately
      #2;
      reset = 1'b1;
      #1;
      check("mid reset out_valid", 32'(out_valid), 32'h0);
      check("mid reset out_data", 32'(out_data), 32'h0);
      check("mid reset stall_count", 32'(stall_count), 32'h0);
      next_cycle();
      reset = 1'b0;

      // After reset requester 0 wins contention again, one-cycle latency
      drive(1'b1, 16'h8000, 1'b1, 16'h1234, 1'b1, 1'b0);
      @(negedge clk);
      check("post reset in0_ready", 32'(in0_ready), 32'h1);
      check("post reset in1_ready", 32'(in1_ready), 32'h0);
      check("post reset out_valid", 32'(out_valid), 32'h0);
      next_cycle();
      drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
      @(negedge clk);
      check("post reset head out_valid", 32'(out_valid), 32'h1);
      check("post reset head out_data", 32'(out_data), 32'hFF8000);
      check("post reset head out_chan", 32'(out_chan), 32'h0);
      next_cycle();
      @(negedge clk);
      check("post reset drained out_valid", 32'(out_valid), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sample_extend_arbiter.md
Name: sample_extend_arbiter

Overview:
- Shares one sign-extension stage between two 16-bit sample requesters, e.g. left/right audio channels or two datapath clients.
- Arbitrates round-robin, widens the granted sample from WIDTH to WIDTH+EXT bits by replicating its MSB, and queues it with a channel tag.
- Queue is a small FIFO drained by a downstream valid/ready consumer.
- Counts back-pressure stall cycles for debug.

Parameters:
- WIDTH, 16, input sample width in bits.
- EXT, 8, number of extension bits; output data width is WIDTH+EXT.
- DEPTH, 4, output FIFO entries; power of two, minimum 2.
- CNT_W, 16, stall counter width.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in0_valid  input  1  requester 0 has a sample.
- in0_data  input  WIDTH  requester 0 sample, two's complement.
- in0_ready  output  1  requester 0 sample accepted this cycle.
- in1_valid  input  1  requester 1 has a sample.
- in1_data  input  WIDTH  requester 1 sample, two's complement.
- in1_ready  output  1  requester 1 sample accepted this cycle.
- out_valid  output  1  FIFO head is valid.
- out_data  output  WIDTH+EXT  sign-extended sample at FIFO head.
- out_chan  output  1  source requester of the head sample (0 or 1).
- out_ready  input  1  consumer accepts head this cycle.
- stall_clr  input  1  synchronous clear of stall_count.
- stall_count  output  CNT_W  saturating count of stalled cycles.

Behaviour:
- Reset (asynchronous, active-high):
  - FIFO count, read pointer and write pointer = 0.
  - out_valid = 0; out_data = 0; out_chan = 0.
  - last_grant = 1, so requester 0 wins the first contention.
  - stall_count = 0.
- Reset asserted mid-operation discards all queued samples. No output handshake completes in that cycle.
- Space: space = (count < DEPTH). A pop in the same cycle does NOT create space; there is no pass-through when full.
- Grant, evaluated combinationally each cycle, only when space = 1:
  - Only in0_valid: grant 0.
  - Only in1_valid: grant 1.
  - Both valid: grant the requester that is not last_grant.
  - Neither valid, or space = 0: no grant.
- Ready outputs:
  - inN_ready = grant==N. At most one ready is high per cycle.
  - Ready never asserts while count==DEPTH.
- A transfer occurs when inN_valid & inN_ready. On the clock edge:
  - Write {{EXT{d[WIDTH-1]}}, d} plus channel tag N at the write pointer.
  - Increment the write pointer modulo DEPTH.
  - last_grant <= N.
- last_grant changes only on a transfer.
- Output side:
  - out_valid = (count != 0).
  - out_data and out_chan present the entry at the read pointer; they are registered, not combinational from inputs.
  - out_data and out_chan hold their value while out_valid & !out_ready.
  - Pop on out_valid & out_ready; the read pointer advances modulo DEPTH.
- Latency: a sample accepted at edge k appears on out_* after edge k, i.e. one cycle minimum when the FIFO was empty.
- Count update:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop in the same cycle: unchanged, with both pointers advancing.
  - Count never exceeds DEPTH and never underflows.
- Ordering: FIFO order strictly equals acceptance order across both channels.
- Stall counter:
  - A stalled cycle is one where (in0_valid | in1_valid) & !space.
  - Each stalled cycle increments stall_count, saturating at all-ones.
  - stall_clr = 1 sets stall_count to 0 and overrides an increment in the same cycle.
- Sign extension examples, WIDTH=16, EXT=8:
  - 16'h8000 -> 24'hFF8000.
  - 16'h7FFF -> 24'h007FFF.
  - 16'hFFFF -> 24'hFFFFFF.
  - 16'h0000 -> 24'h000000.
- Input data is sampled only on a transfer. Valid may drop without a transfer; no obligation is placed on requesters.

Test Plan:
- Reset/first grant: after reset, raise both valids with in0_data=16'h8001 and in1_data=16'h0002, out_ready=1. Expect in0_ready first. Output sequence (chan0, 24'hFF8001), then (chan1, 24'h000002), each out_valid one cycle after its acceptance.
- Round-robin fairness: both valid continuously for 8 cycles, out_ready=1. Expect grants to alternate 0,1,0,1…. Expect 8 outputs with alternating out_chan and stall_count=0.
- Fill/back-pressure: out_ready=0, in0_valid=1 with data 1,2,3,4,5. Expect 4 accepts, then in0_ready=0 and out_valid=1 holding 24'h000001. stall_count increments once per cycle while in0_valid stays high.
- Full with pop: while full, pulse out_ready=1 for one cycle with in0_valid=1. Expect no accept that cycle and count=3. Expect an accept the following cycle and count=4.
- Simultaneous push/pop and wrap: hold count=2 with out_ready=1 and in1_valid=1 for 10 cycles. Expect count to stay at 2, pointers to wrap modulo 4, and data to emerge in input order with correct extension of 16'hFFFF -> 24'hFFFFFF.
- Stall counter: set CNT_W=4 and force 20 stall cycles; expect saturation at 4'hF. Assert stall_clr together with a stall cycle; expect 0 on the next cycle. Assert reset mid-burst; expect out_valid=0 and the queue emptied immediately.
